// File: rtl/enigma_pkg.sv
// Shared Enigma control definitions: letter/position widths, alphabet bound,
// control FSM state encoding and the packed rotor step-flag bundle.
package enigma_pkg;

  localparam int LETTER_W = 5;
  localparam int POS_W    = 7;

  localparam logic [LETTER_W-1:0] ALPHA_MAX = 5'd25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic slow;
    logic mid;
    logic fast;
  } step_flags_t;

endpackage

// File: rtl/enigma_step_decode.sv
// Notch compare: maps rotor positions, letter validity and the double-step
// enable onto fast/mid/slow step flags. Purely combinational.
module enigma_step_decode
  import enigma_pkg::*;
#(
  parameter logic [POS_W-1:0] NOTCH_FAST = 7'd16,
  parameter logic [POS_W-1:0] NOTCH_MID  = 7'd4
) (
  input  logic [POS_W-1:0] pos_fast,
  input  logic [POS_W-1:0] pos_mid,
  input  logic             in_range,
  input  logic             double_step,
  output step_flags_t      flags
);

  logic fast_at_notch;
  logic mid_at_notch;

  // Out-of-range positions never equal a legal notch, so they cause no turnover.
  assign fast_at_notch = (pos_fast == NOTCH_FAST);
  assign mid_at_notch  = (pos_mid == NOTCH_MID);

  assign flags.fast = in_range;
  assign flags.mid  = in_range & (fast_at_notch | (double_step & mid_at_notch));
  assign flags.slow = in_range & mid_at_notch;

endmodule

// File: rtl/enigma_stepper.sv
// Keypress stepping controller: accept one letter, pulse rotor steps, settle, then key_done.
// Define ENIGMA_DOUBLE_STEP_EN for historical middle-rotor double-stepping.
module enigma_stepper
  import enigma_pkg::*;
#(
  parameter logic [POS_W-1:0] NOTCH_FAST    = 7'd16,
  parameter logic [POS_W-1:0] NOTCH_MID     = 7'd4,
  parameter int unsigned      SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [LETTER_W-1:0] key_in,
  output logic                key_ready,
  input  logic                load_busy,
  input  logic [POS_W-1:0]    pos_fast,
  input  logic [POS_W-1:0]    pos_mid,
  input  logic [POS_W-1:0]    pos_slow,
  output logic                step_fast,
  output logic                step_mid,
  output logic                step_slow,
  output logic                key_done,
  output logic [LETTER_W-1:0] key_out,
  output logic                key_err,
  output logic [15:0]         step_count
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

`ifdef ENIGMA_DOUBLE_STEP_EN
  localparam logic DOUBLE_STEP = 1'b1;
`else
  localparam logic DOUBLE_STEP = 1'b0;
`endif

  ctrl_state_t state;
  logic [3:0]  settle_cnt;
  logic        in_range;
  logic        in_range_q;
  logic        accept;
  step_flags_t flags;

  // The slow rotor has nothing above it to turn over, so its position is not needed.
  logic pos_slow_unused;
  assign pos_slow_unused = ^pos_slow;

  assign in_range  = (key_in <= ALPHA_MAX);
  assign key_ready = !reset && (state == IDLE) && !load_busy;
  assign accept    = key_valid && key_ready;

  enigma_step_decode #(
    .NOTCH_FAST (NOTCH_FAST),
    .NOTCH_MID  (NOTCH_MID)
  ) u_decode (
    .pos_fast    (pos_fast),
    .pos_mid     (pos_mid),
    .in_range    (in_range),
    .double_step (DOUBLE_STEP),
    .flags       (flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      in_range_q <= 1'b0;
      step_fast  <= 1'b0;
      step_mid   <= 1'b0;
      step_slow  <= 1'b0;
      key_done   <= 1'b0;
      key_out    <= '0;
      key_err    <= 1'b0;
      step_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            key_out    <= key_in;
            key_err    <= !in_range;
            in_range_q <= in_range;
            step_fast  <= flags.fast;
            step_mid   <= flags.mid;
            step_slow  <= flags.slow;
            state      <= STEP;
          end
        end
        STEP: begin
          step_fast  <= 1'b0;
          step_mid   <= 1'b0;
          step_slow  <= 1'b0;
          settle_cnt <= '0;
          if (in_range_q) step_count <= step_count + 16'd1;
          state <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            key_done <= 1'b1;
            state    <= DONE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        DONE: begin
          key_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_stepper.sv
// Scenario bench for enigma_stepper with an expected-result queue per accepted letter.
module tb_enigma_stepper;

  localparam int SETTLE = 2;

  typedef struct packed {
    logic [2:0] steps;
    logic [4:0] key;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [4:0]  key_in;
  logic        key_ready;
  logic        load_busy;
  logic [6:0]  pos_fast, pos_mid, pos_slow;
  logic        step_fast, step_mid, step_slow;
  logic        key_done;
  logic [4:0]  key_out;
  logic        key_err;
  logic [15:0] step_count;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  enigma_stepper #(
    .NOTCH_FAST    (7'd16),
    .NOTCH_MID     (7'd4),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .load_busy  (load_busy),
    .pos_fast   (pos_fast),
    .pos_mid    (pos_mid),
    .pos_slow   (pos_slow),
    .step_fast  (step_fast),
    .step_mid   (step_mid),
    .step_slow  (step_slow),
    .key_done   (key_done),
    .key_out    (key_out),
    .key_err    (key_err),
    .step_count (step_count)
  );

  function automatic exp_t model(input logic [4:0] k, input logic [6:0] pf, input logic [6:0] pm);
    exp_t e;
    logic ds;
`ifdef ENIGMA_DOUBLE_STEP_EN
    ds = 1'b1;
`else
    ds = 1'b0;
`endif
    e.key      = k;
    e.err      = (k > 5'd25);
    e.steps[0] = !e.err;
    e.steps[1] = !e.err && ((pf == 7'd16) || (ds && (pm == 7'd4)));
    e.steps[2] = !e.err && (pm == 7'd4);
    return e;
  endfunction

  // Present a letter and wait (bounded) for the accepting edge; returns just after it.
  task automatic drive_key(input logic [4:0] k, input logic [6:0] pf, input logic [6:0] pm, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = k;
    pos_fast  = pf;
    pos_mid   = pm;
    for (int i = 0; i < 20; i++) begin
      if (key_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      sb_q.push_back(model(k, pf, pm));
      @(posedge clk);
      #1 key_valid = 1'b0;
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout key=%0d key_ready=%b required 1", k, key_ready);
      key_valid = 1'b0;
    end
  endtask

  // Watch cycles E0+1.. for step pulses and key_done; cycle indices are relative to E0.
  task automatic observe(output bit got, output logic [2:0] st, output int sc, output int dc,
                         output logic [4:0] ko, output logic ke, output logic [15:0] cnt);
    got = 1'b0; st = 3'b000; sc = -1; dc = -1; ko = 'x; ke = 1'bx; cnt = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if ({step_slow, step_mid, step_fast} != 3'b000) begin
        if (sc < 0) sc = c;
        st = st | {step_slow, step_mid, step_fast};
      end
      if (key_done) begin
        got = 1'b1; dc = c; ko = key_out; ke = key_err; cnt = step_count;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_valid = 1'b0; key_in = '0; load_busy = 1'b0;
    pos_fast = '0; pos_mid = '0; pos_slow = '0;
    @(negedge clk);
    n_cmp++;
    if ({step_fast, step_mid, step_slow, key_done, key_out, key_err, step_count} !== 26'd0) begin
      n_bad++; $display("FAIL reset_outputs got=%h required 0", {step_fast, step_mid, step_slow, key_done, key_out, key_err, step_count});
    end
    n_cmp++;
    if (key_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b required 0", key_ready); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (key_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready got=%b required 1", key_ready); end
  endtask

  task automatic test_basic();
    bit ok, got; logic [2:0] st; int sc, dc; logic [4:0] ko; logic ke; logic [15:0] cnt; exp_t e;
    drive_key(5'd7, 7'd0, 7'd0, ok);
    if (ok) begin
      observe(got, st, sc, dc, ko, ke, cnt);
      e = sb_q.pop_front();
      if (!e.err) exp_cnt++;
      n_cmp++; if (!got) begin n_bad++; $display("FAIL basic_done_timeout got=0 required 1"); end
      n_cmp++; if (st !== e.steps) begin n_bad++; $display("FAIL basic_steps got=%b required %b", st, e.steps); end
      n_cmp++; if (sc !== 1) begin n_bad++; $display("FAIL basic_step_cycle got=%0d required 1", sc); end
      n_cmp++; if (dc !== SETTLE + 2) begin n_bad++; $display("FAIL basic_done_cycle got=%0d required %0d", dc, SETTLE + 2); end
      n_cmp++; if (ko !== e.key) begin n_bad++; $display("FAIL basic_key_out got=%0d required %0d", ko, e.key); end
      n_cmp++; if (ke !== e.err) begin n_bad++; $display("FAIL basic_key_err got=%b required %b", ke, e.err); end
      n_cmp++; if (cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL basic_step_count got=%0d required %0d", cnt, exp_cnt); end
    end
  endtask

  task automatic test_mid_turnover();
    bit ok, got; logic [2:0] st; int sc, dc; logic [4:0] ko; logic ke; logic [15:0] cnt; exp_t e;
    drive_key(5'd0, 7'd16, 7'd0, ok);
    if (ok) begin
      observe(got, st, sc, dc, ko, ke, cnt);
      e = sb_q.pop_front();
      if (!e.err) exp_cnt++;
      n_cmp++; if (st !== e.steps) begin n_bad++; $display("FAIL mid_turnover_steps got=%b required %b", st, e.steps); end
      n_cmp++; if (ko !== e.key) begin n_bad++; $display("FAIL mid_turnover_key_out got=%0d required %0d", ko, e.key); end
      n_cmp++; if (cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL mid_turnover_count got=%0d required %0d", cnt, exp_cnt); end
    end
  endtask

  task automatic test_double_step();
    bit ok, got; logic [2:0] st; int sc, dc; logic [4:0] ko; logic ke; logic [15:0] cnt; exp_t e;
    drive_key(5'd25, 7'd3, 7'd4, ok);
    if (ok) begin
      observe(got, st, sc, dc, ko, ke, cnt);
      e = sb_q.pop_front();
      if (!e.err) exp_cnt++;
      n_cmp++; if (st !== e.steps) begin n_bad++; $display("FAIL double_step_steps got=%b required %b", st, e.steps); end
      n_cmp++; if (ke !== e.err) begin n_bad++; $display("FAIL double_step_key_err got=%b required %b", ke, e.err); end
    end
  endtask

  task automatic test_err();
    bit ok, got; logic [2:0] st; int sc, dc; logic [4:0] ko; logic ke; logic [15:0] cnt; exp_t e;
    drive_key(5'd30, 7'd16, 7'd4, ok);
    if (ok) begin
      observe(got, st, sc, dc, ko, ke, cnt);
      e = sb_q.pop_front();
      n_cmp++; if (st !== e.steps) begin n_bad++; $display("FAIL err_steps got=%b required %b", st, e.steps); end
      n_cmp++; if (dc !== SETTLE + 2) begin n_bad++; $display("FAIL err_done_cycle got=%0d required %0d", dc, SETTLE + 2); end
      n_cmp++; if (ke !== e.err) begin n_bad++; $display("FAIL err_key_err got=%b required %b", ke, e.err); end
      n_cmp++; if (ko !== e.key) begin n_bad++; $display("FAIL err_key_out got=%0d required %0d", ko, e.key); end
      n_cmp++; if (cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL err_step_count got=%0d required %0d", cnt, exp_cnt); end
      @(negedge clk);
      n_cmp++; if (key_out !== e.key) begin n_bad++; $display("FAIL err_key_out_hold got=%0d required %0d", key_out, e.key); end
    end
  endtask

  task automatic test_load_busy();
    bit got, seen_rdy, seen_act; logic [2:0] st; int sc, dc; logic [4:0] ko; logic ke; logic [15:0] cnt; exp_t e;
    @(negedge clk);
    load_busy = 1'b1; key_valid = 1'b1; key_in = 5'd12; pos_fast = 7'd0; pos_mid = 7'd0;
    seen_rdy = 1'b0; seen_act = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (key_ready) seen_rdy = 1'b1;
      if (key_done || step_fast) seen_act = 1'b1;
    end
    n_cmp++; if (seen_rdy !== 1'b0) begin n_bad++; $display("FAIL busy_ready got=%b required 0", seen_rdy); end
    n_cmp++; if (seen_act !== 1'b0) begin n_bad++; $display("FAIL busy_accepted got=%b required 0", seen_act); end
    load_busy = 1'b0;
    #1;
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL unbusy_ready got=%b required 1", key_ready); end
    sb_q.push_back(model(5'd12, 7'd0, 7'd0));
    @(posedge clk);
    #1 key_valid = 1'b0;
    observe(got, st, sc, dc, ko, ke, cnt);
    e = sb_q.pop_front();
    if (!e.err) exp_cnt++;
    n_cmp++; if (dc !== SETTLE + 2) begin n_bad++; $display("FAIL unbusy_done_cycle got=%0d required %0d", dc, SETTLE + 2); end
    n_cmp++; if (ko !== e.key) begin n_bad++; $display("FAIL unbusy_key_out got=%0d required %0d", ko, e.key); end
  endtask

  task automatic test_back_to_back();
    bit ok, got, rdy_at_done; logic [2:0] st; int sc, dc, rc; logic [4:0] ko; logic ke; logic [15:0] cnt; exp_t e;
    drive_key(5'd5, 7'd0, 7'd0, ok);
    if (ok) begin
      key_valid = 1'b1; key_in = 5'd9; pos_fast = 7'd16;
      sb_q.push_back(model(5'd9, 7'd16, 7'd0));
      dc = -1; rc = -1; ko = 'x; rdy_at_done = 1'bx;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (key_done && dc < 0) begin dc = c; ko = key_out; rdy_at_done = key_ready; end
        if (key_ready) begin rc = c; break; end
      end
      e = sb_q.pop_front();
      if (!e.err) exp_cnt++;
      n_cmp++; if (dc !== SETTLE + 2) begin n_bad++; $display("FAIL b2b_done_cycle got=%0d required %0d", dc, SETTLE + 2); end
      n_cmp++; if (ko !== e.key) begin n_bad++; $display("FAIL b2b_first_key got=%0d required %0d", ko, e.key); end
      n_cmp++; if (rdy_at_done !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_in_done got=%b required 0", rdy_at_done); end
      n_cmp++; if (rc !== SETTLE + 3) begin n_bad++; $display("FAIL b2b_ready_cycle got=%0d required %0d", rc, SETTLE + 3); end
      @(posedge clk);
      #1 key_valid = 1'b0;
      observe(got, st, sc, dc, ko, ke, cnt);
      e = sb_q.pop_front();
      if (!e.err) exp_cnt++;
      n_cmp++; if (st !== e.steps) begin n_bad++; $display("FAIL b2b_second_steps got=%b required %b", st, e.steps); end
      n_cmp++; if (ko !== e.key) begin n_bad++; $display("FAIL b2b_second_key got=%0d required %0d", ko, e.key); end
      n_cmp++; if (cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL b2b_step_count got=%0d required %0d", cnt, exp_cnt); end
    end
  endtask

  task automatic test_reset_mid_step();
    bit ok, seen_act;
    drive_key(5'd7, 7'd16, 7'd4, ok);
    if (ok) begin
      @(negedge clk);
      n_cmp++; if (step_fast !== 1'b1) begin n_bad++; $display("FAIL rst_mid_step_fast got=%b required 1", step_fast); end
      #2 reset = 1'b1;
      #1;
      void'(sb_q.pop_front());
      exp_cnt = 0;
      n_cmp++;
      if ({step_fast, step_mid, step_slow, key_done, key_out, key_err, step_count} !== 26'd0) begin
        n_bad++; $display("FAIL rst_mid_outputs got=%h required 0", {step_fast, step_mid, step_slow, key_done, key_out, key_err, step_count});
      end
      n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready got=%b required 0", key_ready); end
      @(negedge clk);
      reset = 1'b0;
      seen_act = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (key_done || step_fast || step_mid || step_slow) seen_act = 1'b1;
      end
      n_cmp++; if (seen_act !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pending_pulse got=%b required 0", seen_act); end
      n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready_after got=%b required 1", key_ready); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_mid_turnover();
    test_double_step();
    test_err();
    test_load_busy();
    test_back_to_back();
    test_reset_mid_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
